// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronises and glitch-filters both channels, then turns
// each filtered Gray-code step into an en pulse plus direction for the up/down counter.
module quad_step_decoder #(
    parameter int FILT_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    output logic             en,
    output logic             up,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam int IW = $clog2(FILT_LEN + 2);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(FILT_LEN - 1);
    localparam logic [IW-1:0]    INIT_LAST = IW'(FILT_LEN + 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic {ST_INIT, ST_TRACK} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic [1:0]       sync_a_q, sync_a_d;
    logic [1:0]       sync_b_q, sync_b_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d;
    logic [CW-1:0]    cnt_b_q, cnt_b_d;
    logic [1:0]       filt_q, filt_d;   // {A,B}
    logic [1:0]       prev_q, prev_d;
    logic             en_q, en_d;
    logic             up_q, up_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [1:0]  s2;
    logic [1:0]  step;
    logic [CW:0] res_a, res_b;

    // Returns {new filtered value, new counter} for one channel.
    function automatic logic [CW:0] filt_step(input logic s, input logic f, input logic [CW-1:0] c);
        logic [CW:0] r;
        if (s == f) begin
            r = {f, {CW{1'b0}}};
        end else if (c == CNT_LAST) begin
            r = {s, {CW{1'b0}}};
        end else begin
            r = {f, c + 1'b1};
        end
        return r;
    endfunction

    // Position along the forward sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        logic [1:0] p;
        case (ab)
            2'b00:   p = 2'd0;
            2'b10:   p = 2'd1;
            2'b11:   p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

    always_comb begin
        sync_a_d   = {sync_a_q[0], a_in};
        sync_b_d   = {sync_b_q[0], b_in};
        s2         = {sync_a_q[1], sync_b_q[1]};
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        filt_d     = filt_q;
        prev_d     = filt_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        en_d       = 1'b0;
        err_d      = 1'b0;
        up_d       = up_q;
        err_cnt_d  = err_cnt_q;
        // Modulo-4 distance: 1 forward, 3 reverse, 2 both bits flipped.
        step       = gray_pos(filt_q) - gray_pos(prev_q);
        res_a      = filt_step(s2[1], filt_q[1], cnt_a_q);
        res_b      = filt_step(s2[0], filt_q[0], cnt_b_q);

        case (state_q)
            ST_INIT: begin
                // Track the resting position directly so leaving INIT sees no step.
                filt_d     = s2;
                prev_d     = s2;
                cnt_a_d    = '0;
                cnt_b_d    = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_TRACK;
                    init_cnt_d = '0;
                end
            end
            default: begin
                filt_d  = {res_a[CW], res_b[CW]};
                cnt_a_d = res_a[CW-1:0];
                cnt_b_d = res_b[CW-1:0];
                case (step)
                    2'd1: begin
                        en_d = 1'b1;
                        up_d = 1'b1;
                    end
                    2'd3: begin
                        en_d = 1'b1;
                        up_d = 1'b0;
                    end
                    2'd2: begin
                        err_d = 1'b1;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            en_q       <= 1'b0;
            up_q       <= 1'b1;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sync_a_q   <= sync_a_d;
            sync_b_q   <= sync_b_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            en_q       <= en_d;
            up_q       <= up_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign en      = en_q;
    assign up      = up_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule
